// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: turns hazard, branch, memory-wait and halt
// events into one consistent set of pipeline-register enables and flushes.
module pipe_seq_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              haz_stall,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt,
    input  logic              resume,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [2:0]        state,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        STALL = 3'd1,
        FLUSH = 3'd2,
        MEMW  = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Control word layout: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] CTL_FLUSH  = 7'b11111_11;
    localparam logic [6:0] CTL_STALL  = 7'b00111_01;
    localparam logic [6:0] CTL_FREEZE = 7'b00000_00;
    localparam logic [6:0] CTL_RESET  = 7'b00000_11;

    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q;
    state_t     state_nxt;
    logic [2:0] cnt_q;
    logic [2:0] cnt_nxt;
    logic [6:0] ctl;
    logic       mem_wait;
    logic       run_dec;

    assign mem_wait = mem_req & ~mem_ready;

    always_comb begin
        ctl       = CTL_RUN;
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
        run_dec   = 1'b0;
        if (rst) begin
            ctl = CTL_RESET;
        end else begin
            case (state_q)
                RUN: run_dec = 1'b1;
                STALL: begin
                    if (mem_wait) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = MEMW;
                    end else if (br_taken) begin
                        run_dec = 1'b1;
                    end else begin
                        ctl = CTL_STALL;
                        if (cnt_q > 3'd1) begin
                            state_nxt = STALL;
                            cnt_nxt   = cnt_q - 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_wait) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = MEMW;
                    end else begin
                        ctl = CTL_FLUSH;
                        if (br_taken) begin
                            if (FLUSH_CYCLES > 1) begin
                                state_nxt = FLUSH;
                                cnt_nxt   = FLUSH_RELOAD;
                            end
                        end else if (cnt_q > 3'd1) begin
                            state_nxt = FLUSH;
                            cnt_nxt   = cnt_q - 3'd1;
                        end
                    end
                end
                MEMW: begin
                    // Once the access completes, the pending events are decoded
                    // exactly as RUN would have, so nothing is lost during the wait.
                    if (!mem_ready) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = MEMW;
                    end else begin
                        run_dec = 1'b1;
                    end
                end
                HALT: begin
                    if (mem_wait) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = HALT;
                    end else if (!resume) begin
                        ctl       = CTL_STALL;
                        state_nxt = HALT;
                    end
                end
                default: ;
            endcase

            if (run_dec) begin
                if (mem_wait) begin
                    ctl       = CTL_FREEZE;
                    state_nxt = MEMW;
                end else if (br_taken) begin
                    ctl = CTL_FLUSH;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end
                end else if (haz_stall) begin
                    ctl = CTL_STALL;
                    if (STALL_CYCLES > 1) begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_RELOAD;
                    end
                end else if (halt) begin
                    ctl       = CTL_STALL;
                    state_nxt = HALT;
                end
            end
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = ctl;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_count <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (!pc_en && (stall_count != {PERF_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed table-driven bench for pipe_seq_ctrl, plus hand sequences for
// counter saturation and reset in the middle of a stall.
module tb_pipe_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       haz_stall = 1'b0, br_taken = 1'b0, mem_req = 1'b0;
    logic       mem_ready = 1'b0, halt = 1'b0, resume = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [2:0] state;
    logic [7:0] stall_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    pipe_seq_ctrl #(.STALL_CYCLES(2), .FLUSH_CYCLES(2), .PERF_W(8)) dut (
        .clk(clk), .rst(rst), .haz_stall(haz_stall), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Inputs: {rst, haz_stall, br_taken, mem_req, mem_ready, halt, resume}
    localparam logic [6:0] I_IDLE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_HAZ  = 7'b0100000;
    localparam logic [6:0] I_BR   = 7'b0010000;
    localparam logic [6:0] I_MREQ = 7'b0001000;
    localparam logic [6:0] I_MRDY = 7'b0000100;
    localparam logic [6:0] I_HALT = 7'b0000010;
    localparam logic [6:0] I_RES  = 7'b0000001;

    // Outputs: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] O_RUN = 7'b11111_00;
    localparam logic [6:0] O_FL  = 7'b11111_11;
    localparam logic [6:0] O_ST  = 7'b00111_01;
    localparam logic [6:0] O_FRZ = 7'b00000_00;
    localparam logic [6:0] O_RST = 7'b00000_11;

    typedef struct {
        string      name;
        logic [6:0] stim;
        logic [6:0] exp_out;
        logic       chk_regs;
        logic [2:0] exp_state;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [6:0] stim, input logic [6:0] exp_out,
                       input logic chk_regs, input logic [2:0] exp_state, input logic [7:0] exp_count);
        vec_t v;
        v.name = name; v.stim = stim; v.exp_out = exp_out;
        v.chk_regs = chk_regs; v.exp_state = exp_state; v.exp_count = exp_count;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic [6:0] stim);
        {rst, haz_stall, br_taken, mem_req, mem_ready, halt, resume} = stim;
    endtask

    task automatic check_output(input string name, input logic [6:0] exp_out, input logic chk_regs,
                                input logic [2:0] exp_state, input logic [7:0] exp_count);
        logic [6:0] act;
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        n_compared++;
        if (act !== exp_out) begin
            n_mismatched++;
            $display("[TB] FAIL %s ctl: got %b required %b", name, act, exp_out);
        end
        if (chk_regs) begin
            n_compared++;
            if (state !== exp_state) begin
                n_mismatched++;
                $display("[TB] FAIL %s state: got %0d required %0d", name, state, exp_state);
            end
            n_compared++;
            if (stall_count !== exp_count) begin
                n_mismatched++;
                $display("[TB] FAIL %s stall_count: got %0d required %0d", name, stall_count, exp_count);
            end
        end
    endtask

    task automatic step(input string name, input logic [6:0] stim, input logic [6:0] exp_out,
                        input logic chk_regs, input logic [2:0] exp_state, input logic [7:0] exp_count);
        apply_stimulus(stim);
        @(negedge clk);
        check_output(name, exp_out, chk_regs, exp_state, exp_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        add("rst0",      I_RST,  O_RST, 1'b0, 3'd0, 8'd0);
        add("rst1",      I_RST,  O_RST, 1'b1, 3'd0, 8'd0);
        add("idle",      I_IDLE, O_RUN, 1'b1, 3'd0, 8'd0);
        add("haz",       I_HAZ,  O_ST,  1'b1, 3'd0, 8'd0);
        add("haz_st",    I_IDLE, O_ST,  1'b1, 3'd1, 8'd1);
        add("haz_end",   I_IDLE, O_RUN, 1'b1, 3'd0, 8'd2);
        add("brhaz",     I_BR | I_HAZ, O_FL, 1'b1, 3'd0, 8'd2);
        add("brhaz_fl",  I_IDLE, O_FL,  1'b1, 3'd2, 8'd2);
        add("brhaz_end", I_IDLE, O_RUN, 1'b1, 3'd0, 8'd2);
        add("mw0",       I_MREQ | I_BR, O_FRZ, 1'b1, 3'd0, 8'd2);
        add("mw1",       I_MREQ | I_BR, O_FRZ, 1'b1, 3'd3, 8'd3);
        add("mw2",       I_MREQ | I_BR, O_FRZ, 1'b1, 3'd3, 8'd4);
        add("mw3",       I_MREQ | I_BR, O_FRZ, 1'b1, 3'd3, 8'd5);
        add("mw_rdy",    I_MREQ | I_MRDY | I_BR, O_FL, 1'b1, 3'd3, 8'd6);
        add("mw_fl",     I_IDLE, O_FL,  1'b1, 3'd2, 8'd6);
        add("mw_end",    I_IDLE, O_RUN, 1'b1, 3'd0, 8'd6);
        add("halt",      I_HALT, O_ST,  1'b1, 3'd0, 8'd6);
        for (int i = 0; i < 5; i++)
            add($sformatf("halted%0d", i), I_IDLE, O_ST, 1'b1, 3'd4, 8'(7 + i));
        add("resume",    I_RES,  O_RUN, 1'b1, 3'd4, 8'd12);
        add("resumed",   I_IDLE, O_RUN, 1'b1, 3'd0, 8'd12);
        add("prio_all",  I_HAZ | I_BR | I_MREQ | I_HALT, O_FRZ, 1'b1, 3'd0, 8'd12);
        add("prio_rdy",  I_HAZ | I_BR | I_MREQ | I_MRDY | I_HALT, O_FL, 1'b1, 3'd3, 8'd13);
        add("fl_reload", I_BR,   O_FL,  1'b1, 3'd2, 8'd13);
        add("fl_last",   I_IDLE, O_FL,  1'b1, 3'd2, 8'd13);
        add("fl_done",   I_IDLE, O_RUN, 1'b1, 3'd0, 8'd13);
        add("st_haz",    I_HAZ,  O_ST,  1'b1, 3'd0, 8'd13);
        add("st_mem",    I_MREQ, O_FRZ, 1'b1, 3'd1, 8'd14);
        add("st_mrdy",   I_MREQ | I_MRDY, O_RUN, 1'b1, 3'd3, 8'd15);
        add("st_run",    I_IDLE, O_RUN, 1'b1, 3'd0, 8'd15);
        add("h_halt",    I_HALT, O_ST,  1'b1, 3'd0, 8'd15);
        add("h_mem",     I_MREQ, O_FRZ, 1'b1, 3'd4, 8'd16);
        add("h_ignore",  I_HALT, O_ST,  1'b1, 3'd4, 8'd17);
        add("h_resume",  I_RES,  O_RUN, 1'b1, 3'd4, 8'd18);
        add("h_run",     I_IDLE, O_RUN, 1'b1, 3'd0, 8'd18);
        add("sb_haz",    I_HAZ,  O_ST,  1'b1, 3'd0, 8'd18);
        add("sb_br",     I_BR,   O_FL,  1'b1, 3'd1, 8'd19);
        add("sb_fl",     I_IDLE, O_FL,  1'b1, 3'd2, 8'd19);
        add("sb_run",    I_IDLE, O_RUN, 1'b1, 3'd0, 8'd19);

        @(posedge clk);
        #1;
        foreach (vecs[i])
            step(vecs[i].name, vecs[i].stim, vecs[i].exp_out, vecs[i].chk_regs,
                 vecs[i].exp_state, vecs[i].exp_count);

        // Hold HALT long enough to drive the 8-bit counter past its ceiling.
        step("sat_halt", I_HALT, O_ST, 1'b1, 3'd0, 8'd19);
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(I_IDLE);
            @(posedge clk);
            #1;
        end
        step("sat_hold",   I_IDLE, O_ST,  1'b1, 3'd4, 8'd255);
        step("sat_resume", I_RES,  O_RUN, 1'b1, 3'd4, 8'd255);
        step("sat_run",    I_IDLE, O_RUN, 1'b1, 3'd0, 8'd255);

        // Reset arriving while a stall is still counting down.
        step("mr_haz",     I_HAZ,  O_ST,  1'b1, 3'd0, 8'd255);
        step("mr_rst",     I_RST,  O_RST, 1'b1, 3'd1, 8'd255);
        step("mr_after",   I_IDLE, O_RUN, 1'b1, 3'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. Sits beside the hazard detection unit and owns every pipeline-register enable and flush. Merges four event sources into one consistent enable/flush vector per cycle: load/store stall requests, taken branches from EX, multi-cycle data-memory waits and HALT/resume. Runs a small FSM with a cycle counter and keeps a saturating stall-cycle performance counter.

Parameters:
STALL_CYCLES, 1, bubble cycles per hazard stall (legal 1..7)
FLUSH_CYCLES, 2, cycles IF/ID and ID/EX are flushed after a taken branch (legal 1..7)
PERF_W, 8, width of the stall performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
haz_stall  input  1  stall request from hazard detection (level)
br_taken  input  1  branch resolved taken in EX (level, valid each cycle)
mem_req  input  1  MEM stage holds a load/store
mem_ready  input  1  data memory completes the access this cycle
halt  input  1  HALT instruction decoded in ID
resume  input  1  restart request from debug/testbench
pc_en  output  1  PC write enable
ifid_en  output  1  IF/ID register enable
idex_en  output  1  ID/EX register enable
exmem_en  output  1  EX/MEM register enable
memwb_en  output  1  MEM/WB register enable
ifid_flush  output  1  load NOP into IF/ID
idex_flush  output  1  load NOP (bubble) into ID/EX
state  output  3  current FSM state (debug)
stall_count  output  PERF_W  cycles with pc_en=0, saturating

Behaviour:
- Outputs are Mealy: decoded combinationally from state, counter and current inputs. State, counter and stall_count update on clk.
- State codes: RUN=0, STALL=1, FLUSH=2, MEMW=3, HALT=4. Codes 5-7 are illegal and go to RUN next cycle with RUN outputs.
- While rst=1: all five enables 0, both flushes 1. Next state RUN, cnt=0, stall_count=0.
- RUN decode, priority highest first:
  (a) mem_req & !mem_ready: all enables 0, no flush; next MEMW.
  (b) br_taken: all enables 1, ifid_flush=idex_flush=1. Next FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  (c) haz_stall: pc_en=ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1. Next STALL with cnt=STALL_CYCLES-1 if STALL_CYCLES>1, else RUN.
  (d) halt: same outputs as (c); next HALT.
  (e) none: all enables 1, flushes 0; stay RUN.
- STALL: (a) has priority (freeze, go MEMW, remaining count discarded). Otherwise outputs as RUN(c). cnt decrements; at cnt=1 next is RUN. The hazard unit re-asserts haz_stall if still needed. br_taken in STALL is decoded as RUN(b).
- FLUSH: (a) has priority. Otherwise outputs as RUN(b); cnt decrements; RUN when cnt reaches 1. A new br_taken reloads cnt=FLUSH_CYCLES-1.
- MEMW: mem_ready=0 gives all enables 0 and stay. mem_ready=1 decodes as RUN with rule (a) masked, same cycle, and takes the next state RUN(b..e) would take. No event is lost across the wait.
- HALT: pc_en=ifid_en=0, idex_flush=1, back stages enabled so the pipe drains. (a) still freezes but returns to HALT, not RUN. resume=1 gives RUN outputs (e) that cycle and next RUN. halt is ignored in HALT.
- Simultaneous events follow the priorities: mem > branch > hazard > halt.
- stall_count increments in every non-reset cycle where pc_en=0; holds at 2^PERF_W-1.
- Reset mid-stall, flush or wait: next cycle is RUN, all counters cleared.

Test Plan:
- Reset for 2 cycles, then idle -> during rst enables=0 and flushes=1; next cycle state=0, all enables 1, stall_count=0.
- haz_stall 1 cycle, STALL_CYCLES=2 -> pc_en=ifid_en=0 and idex_flush=1 for exactly 2 cycles, state 0→1→0, stall_count=2.
- br_taken and haz_stall in the same cycle, FLUSH_CYCLES=2 -> flush wins: ifid_flush=idex_flush=1 for 2 cycles, pc_en=1 throughout, stall_count unchanged.
- mem_req=1, mem_ready low 3 cycles, br_taken held -> all enables 0 for 4 cycles (RUN + 3 MEMW). On the mem_ready cycle enables are 1 and flushes are 1, then state=2.
- halt, then resume after 5 cycles -> pc_en=0 for 6 cycles, state=4, stall_count=6. On the resume cycle pc_en=1, then state=0.
- Force 300 stall cycles with PERF_W=8 -> stall_count saturates at 255. Assert rst mid-STALL -> state=0 and stall_count=0 on the next cycle.
